// File: rtl/random_range.sv
// Pseudo-random value source: prescaled counter/Galois-LFSR state, req/valid handshake
// returning a value in [LO, HI]; out-of-range states are resampled, then clamped after MAX_TRIES ticks.
module random_range #(
  parameter int               WIDTH     = 7,
  parameter int               DIV_W     = 3,
  parameter int               LO        = 8,
  parameter int               HI        = 119,
  parameter logic [WIDTH-1:0] POLY      = 7'h60,
  parameter int               SEED      = 1,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] divider_in,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  localparam int TRIES_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

  localparam logic [WIDTH-1:0]   LO_V      = WIDTH'(LO);
  localparam logic [WIDTH-1:0]   HI_V      = WIDTH'(HI);
  localparam logic [WIDTH-1:0]   SEED_V    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]   ONE_V     = WIDTH'(1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

  typedef enum logic {
    IDLE,
    SAMPLE
  } fsm_t;

  fsm_t               fsm;
  logic [DIV_W-1:0]   div_cnt;
  logic [WIDTH-1:0]   state;
  logic [TRIES_W-1:0] tries;

  logic               div_hit;
  logic               tick;
  logic [WIDTH-1:0]   lfsr_next;
  logic               in_range;
  logic [WIDTH-1:0]   clamp_val;

  // A seed load restarts the tick period, so the loaded value is never advanced in the same edge.
  assign div_hit = (div_cnt == divider_in);
  assign tick    = div_hit && !seed_load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (seed_load || div_hit) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign lfsr_next = (state >> 1) ^ (state[0] ? POLY : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SEED_V;
    end else if (seed_load) begin
      state <= seed;
    end else if (tick) begin
      if (!mode) begin
        state <= state + 1'b1;
      end else if (state == '0) begin
        state <= ONE_V;
      end else begin
        state <= lfsr_next;
      end
    end
  end

  assign in_range = (state >= LO_V) && (state <= HI_V);

  always_comb begin
    clamp_val = state;
    if (state < LO_V) begin
      clamp_val = LO_V;
    end else if (state > HI_V) begin
      clamp_val = HI_V;
    end
  end

  // ready mirrors fsm == IDLE but is kept as its own flop so the output is registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm   <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      out   <= LO_V;
      tries <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            if (in_range) begin
              out   <= state;
              valid <= 1'b1;
            end else begin
              valid <= 1'b0;
              tries <= '0;
              fsm   <= SAMPLE;
              ready <= 1'b0;
            end
          end
        end
        SAMPLE: begin
          if (in_range) begin
            out   <= state;
            valid <= 1'b1;
            fsm   <= IDLE;
            ready <= 1'b1;
          end else if (tries == TRIES_MAX) begin
            out   <= clamp_val;
            valid <= 1'b1;
            fsm   <= IDLE;
            ready <= 1'b1;
          end else if (tick) begin
            tries <= tries + 1'b1;
          end
        end
        default: begin
          fsm   <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_range.sv
// Scoreboard bench for random_range: stimulus queues expected value and latency per request,
// a negedge monitor pairs each accepted request with its delivery.
module tb_random_range;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] divider_in;
  logic       mode;
  logic       seed_load;
  logic [6:0] seed;
  logic       req;
  logic       ready;
  logic       valid;
  logic [6:0] out;

  always #5 clk = ~clk;

  random_range dut (
    .clk        (clk),
    .resetn     (resetn),
    .divider_in (divider_in),
    .mode       (mode),
    .seed_load  (seed_load),
    .seed       (seed),
    .req        (req),
    .ready      (ready),
    .valid      (valid),
    .out        (out)
  );

  typedef struct {
    logic [6:0] val;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   busy = 1'b0;
  int   wait_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Monitor: an accepted request completes at the first later negedge where ready is high.
  always @(negedge clk) begin
    if (!resetn) begin
      busy     = 1'b0;
      wait_cyc = 0;
    end else begin
      if (busy) begin
        wait_cyc++;
        if (ready) begin
          busy = 1'b0;
          check("expected entry present", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", out, e.val);
            check("valid at delivery", valid, 1);
            check("latency", wait_cyc, e.lat);
          end
        end else if (wait_cyc > 100) begin
          check("delivery wait bound", wait_cyc, 100);
          busy = 1'b0;
        end
      end
      if (ready && req) begin
        busy     = 1'b1;
        wait_cyc = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] s);
    seed      = s;
    seed_load = 1'b1;
    cyc(1);
    seed_load = 1'b0;
  endtask

  task automatic push(input logic [6:0] v, input int lat);
    exp_t t;
    t.val = v;
    t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic ask(input logic [6:0] v, input int lat);
    push(v, lat);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      cyc(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    int first_one;

    resetn     = 1'b0;
    divider_in = 3'd0;
    mode       = 1'b0;
    seed_load  = 1'b0;
    seed       = 7'd0;
    req        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", out, 8);
    check("reset valid", valid, 0);
    check("reset ready", ready, 1);
    check("reset state", dut.state, 1);
    resetn = 1'b1;
    cyc(1);

    // Counter hit and bound edges
    load(7'd20);
    ask(7'd20, 1);
    check("ready after hit", ready, 1);
    drain("drain counter hit");
    load(7'd8);
    ask(7'd8, 1);
    load(7'd119);
    ask(7'd119, 1);
    drain("drain bounds");
    load(7'd7);
    ask(7'd8, 2);
    drain("drain one miss");

    // Full-rate requests
    load(7'd20);
    push(7'd20, 1);
    push(7'd21, 1);
    push(7'd22, 1);
    req = 1'b1;
    cyc(3);
    req = 1'b0;
    drain("drain back-to-back");

    // Seed load together with req uses the pre-load state
    load(7'd30);
    seed      = 7'd5;
    seed_load = 1'b1;
    push(7'd30, 1);
    req = 1'b1;
    cyc(1);
    seed_load = 1'b0;
    req       = 1'b0;
    check("state after concurrent load", dut.state, 5);
    drain("drain concurrent load");

    // Timeout clamp: 121..127,0,1 rejected
    load(7'd120);
    ask(7'd8, 10);
    drain("drain timeout");

    // Prescaler: divider 3, 16 cycles -> 4 ticks
    divider_in = 3'd3;
    load(7'd0);
    cyc(16);
    check("prescaled state", dut.state, 4);
    ask(7'd8, 17);
    drain("drain prescaler");
    divider_in = 3'd0;

    // LFSR: lock-up escape, known steps, period 127
    mode = 1'b1;
    load(7'd0);
    cyc(1);
    check("lfsr escape", dut.state, 1);
    zeros     = 0;
    first_one = -1;
    for (int n = 1; n <= 127; n++) begin
      cyc(1);
      if (dut.state == 7'd0) zeros++;
      if (dut.state == 7'd1 && first_one < 0) first_one = n;
      if (n == 1) check("lfsr step 1", dut.state, 96);
      if (n == 2) check("lfsr step 2", dut.state, 48);
      if (n == 7) check("lfsr step 7", dut.state, 97);
    end
    check("lfsr zero count", zeros, 0);
    check("lfsr period", first_one, 127);
    load(7'd96);
    ask(7'd96, 1);
    drain("drain lfsr hit");
    mode = 1'b0;

    // Reset during SAMPLE cycle 4
    load(7'd120);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    cyc(3);
    check("in sample before reset", ready, 0);
    resetn = 1'b0;
    #1;
    check("abort out", out, 8);
    check("abort valid", valid, 0);
    check("abort ready", ready, 1);
    check("abort state", dut.state, 1);
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    load(7'd20);
    ask(7'd20, 1);
    drain("drain after abort");

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
